// File: rtl/param_multiplier_top.sv
// Register-mapped shift-add multiplier (WIDTH x WIDTH -> 2*WIDTH) with busy/done status and interrupt.
// Build option MUL_SIGNED_EN enables the MODE register for two's-complement multiplication.
module param_multiplier_top #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        S_sel,
  input  logic        S_wr,
  input  logic [7:0]  S_address,
  input  logic [31:0] S_din,
  output logic [31:0] S_dout,
  output logic        m_interrupt
);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t                    state;
  logic        [WIDTH-1:0]   opa, opb;
  logic signed [WIDTH-1:0]   opa_s, opb_s;
  logic                      intr_en;
  logic                      mode;
  logic                      done;
  logic        [PW-1:0]      result;
  logic                      res_sgn;
  logic        [PW-1:0]      mcand;
  logic        [WIDTH-1:0]   mplier;
  logic        [PW-1:0]      acc;
  logic        [5:0]         cnt;
  logic                      neg;
  logic                      busy;
  logic                      wr;
  logic                      wr_start;
  logic                      wr_clear;
  logic                      sign_a, sign_b;
  logic        [63:0]        prod_ext;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_neg);
    return is_neg ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] p, input logic is_neg);
    return is_neg ? (~p + PW'(1)) : p;
  endfunction

  assign busy     = (state == EXEC);
  assign wr       = S_sel & S_wr;
  assign wr_start = wr && (S_address == 8'h05) && S_din[0];
  assign wr_clear = wr && (S_address == 8'h06) && S_din[0];
  assign opa_s    = opa;
  assign opb_s    = opb;
  assign sign_a   = mode && (opa_s < 0);
  assign sign_b   = mode && (opb_s < 0);

  // Configuration registers; operands and MODE are frozen while an operation runs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opa     <= '0;
      opb     <= '0;
      intr_en <= 1'b0;
    end else if (wr) begin
      if (S_address == 8'h00 && !busy) opa <= S_din[WIDTH-1:0];
      if (S_address == 8'h01 && !busy) opb <= S_din[WIDTH-1:0];
      if (S_address == 8'h04)          intr_en <= S_din[0];
    end
  end

`ifdef MUL_SIGNED_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      mode <= 1'b0;
    else if (wr && S_address == 8'h08 && !busy)
      mode <= S_din[0];
  end
`else
  assign mode = 1'b0;
`endif

  // Control FSM and shift-add datapath: magnitudes are multiplied, sign applied on the final edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      done    <= 1'b0;
      result  <= '0;
      res_sgn <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
    end else if (wr_clear) begin
      state   <= IDLE;
      done    <= 1'b0;
      result  <= '0;
      res_sgn <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (wr_start) begin
            mcand  <= PW'(magnitude(opa, sign_a));
            mplier <= magnitude(opb, sign_b);
            neg    <= sign_a ^ sign_b;
            acc    <= '0;
            cnt    <= 6'(WIDTH);
            done   <= 1'b0;
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 6'd1;
          end else begin
            result  <= apply_sign(acc, neg);
            res_sgn <= mode;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RESULT is viewed as a 64-bit value, sign-extended only for signed-mode products.
  always_comb begin
    prod_ext         = {64{res_sgn & result[PW-1]}};
    prod_ext[PW-1:0] = result;
  end

  always_comb begin
    S_dout = '0;
    if (S_sel && !S_wr) begin
      case (S_address)
        8'h00:   S_dout = 32'(opa);
        8'h01:   S_dout = 32'(opb);
        8'h02:   S_dout = prod_ext[31:0];
        8'h03:   S_dout = prod_ext[63:32];
        8'h04:   S_dout = {31'b0, intr_en};
        8'h07:   S_dout = {30'b0, busy, done};
        8'h08:   S_dout = {31'b0, mode};
        default: S_dout = '0;
      endcase
    end
  end

  assign m_interrupt = done & intr_en;

endmodule

// File: tb/tb_param_multiplier_top.sv
// Directed bench for param_multiplier_top: a 32-bit and an 8-bit instance share one bus.
module tb_param_multiplier_top;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        S_sel = 1'b0;
  logic        S_wr = 1'b0;
  logic [7:0]  S_address = '0;
  logic [31:0] S_din = '0;
  logic [31:0] dout32, dout8;
  logic        irq32, irq8;
  logic [31:0] r32, r8;
  int          total = 0;
  int          bad = 0;

`ifdef MUL_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  param_multiplier_top #(.WIDTH(32)) u32 (
    .clk(clk), .reset_n(reset_n), .S_sel(S_sel), .S_wr(S_wr),
    .S_address(S_address), .S_din(S_din), .S_dout(dout32), .m_interrupt(irq32)
  );

  param_multiplier_top #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(reset_n), .S_sel(S_sel), .S_wr(S_wr),
    .S_address(S_address), .S_din(S_din), .S_dout(dout8), .m_interrupt(irq8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    S_sel = 1'b1; S_wr = 1'b1; S_address = a; S_din = d;
    @(posedge clk);
    #1;
    S_sel = 1'b0; S_wr = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d, output logic [31:0] d8);
    S_sel = 1'b1; S_wr = 1'b0; S_address = a;
    #1;
    d = dout32; d8 = dout8;
    S_sel = 1'b0;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    rd(8'h07, r32, r8); chk("rst_status", r32, 32'h0);
    chk("rst_irq", {31'b0, irq32}, 32'h0);
    @(negedge clk); reset_n = 1'b1;
    #1;
    rd(8'h02, r32, r8); chk("rst_lo", r32, 32'h0);

    // Test 1: 0x40 * 0x50, exact latency, interrupt disabled
    wr(8'h04, 32'h0);
    wr(8'h00, 32'h40);
    wr(8'h01, 32'h50);
    rd(8'h00, r32, r8); chk("opa_rb", r32, 32'h40);
    wr(8'h05, 32'h1);
    rd(8'h07, r32, r8); chk("t1_busy", r32, 32'h2);
    edges(32);
    rd(8'h07, r32, r8); chk("t1_busy_e32", r32, 32'h2);
    edges(1);
    rd(8'h07, r32, r8); chk("t1_done_e33", r32, 32'h1);
    rd(8'h02, r32, r8); chk("t1_lo", r32, 32'h00001400);
    rd(8'h03, r32, r8); chk("t1_hi", r32, 32'h0);
    chk("t1_irq_off", {31'b0, irq32}, 32'h0);

    // Test 3: late interrupt enable, then clear
    wr(8'h04, 32'h1);
    chk("t3_irq_on", {31'b0, irq32}, 32'h1);
    wr(8'h06, 32'h1);
    chk("t3_irq_clr", {31'b0, irq32}, 32'h0);
    rd(8'h07, r32, r8); chk("t3_status", r32, 32'h0);
    rd(8'h02, r32, r8); chk("t3_lo", r32, 32'h0);

    // Test 2: all-ones operands on both widths
    wr(8'h00, 32'hFFFFFFFF);
    wr(8'h01, 32'hFFFFFFFF);
    wr(8'h05, 32'h1);
    edges(40);
    rd(8'h02, r32, r8); chk("t2_lo32", r32, 32'h00000001); chk("t2_lo8", r8, 32'h0000FE01);
    rd(8'h03, r32, r8); chk("t2_hi32", r32, 32'hFFFFFFFE); chk("t2_hi8", r8, 32'h0);
    chk("t2_irq32", {31'b0, irq32}, 32'h1);
    chk("t2_irq8", {31'b0, irq8}, 32'h1);

    // Test 4: writes and START ignored while busy, CLEAR aborts
    wr(8'h06, 32'h1);
    wr(8'h05, 32'h1);
    edges(10);
    wr(8'h00, 32'h7);
    wr(8'h05, 32'h1);
    rd(8'h07, r32, r8); chk("t4_busy", r32, 32'h2);
    wr(8'h06, 32'h1);
    rd(8'h00, r32, r8); chk("t4_opa_kept", r32, 32'hFFFFFFFF);
    rd(8'h07, r32, r8); chk("t4_idle", r32, 32'h0);
    rd(8'h02, r32, r8); chk("t4_lo0", r32, 32'h0);
    rd(8'h03, r32, r8); chk("t4_hi0", r32, 32'h0);
    edges(40);
    rd(8'h07, r32, r8); chk("t4_norestart", r32, 32'h0);
    wr(8'h05, 32'h1);
    edges(33);
    rd(8'h07, r32, r8); chk("t4_done", r32, 32'h1);
    rd(8'h02, r32, r8); chk("t4_lo", r32, 32'h00000001);
    wr(8'h05, 32'h1);
    edges(5);
    rd(8'h02, r32, r8); chk("t4_lo_hold", r32, 32'h00000001);
    rd(8'h07, r32, r8); chk("t4_rebusy", r32, 32'h2);
    wr(8'h06, 32'h1);

    // Zero operand, reserved address, write to read-only register
    wr(8'h00, 32'h0);
    wr(8'h01, 32'h1234);
    wr(8'h02, 32'hDEADBEEF);
    wr(8'h05, 32'h1);
    edges(33);
    rd(8'h02, r32, r8); chk("zero_lo", r32, 32'h0);
    rd(8'h03, r32, r8); chk("zero_hi", r32, 32'h0);
    rd(8'h07, r32, r8); chk("zero_done", r32, 32'h1);
    rd(8'h09, r32, r8); chk("reserved", r32, 32'h0);

    // Test 5: -3 * 5 in MODE=1 (signed only when built with the option), then MODE=0
    wr(8'h08, 32'h1);
    rd(8'h08, r32, r8); chk("t5_mode", r32, SIGNED_BUILD ? 32'h1 : 32'h0);
    wr(8'h00, 32'hFFFFFFFD);
    wr(8'h01, 32'h5);
    wr(8'h05, 32'h1);
    edges(33);
    rd(8'h02, r32, r8);
    chk("t5_lo32", r32, 32'hFFFFFFF1);
    chk("t5_lo8", r8, SIGNED_BUILD ? 32'hFFFFFFF1 : 32'h000004F1);
    rd(8'h03, r32, r8);
    chk("t5_hi32", r32, SIGNED_BUILD ? 32'hFFFFFFFF : 32'h00000004);
    chk("t5_hi8", r8, SIGNED_BUILD ? 32'hFFFFFFFF : 32'h0);
    wr(8'h08, 32'h0);
    wr(8'h05, 32'h1);
    edges(33);
    rd(8'h02, r32, r8); chk("t5u_lo32", r32, 32'hFFFFFFF1); chk("t5u_lo8", r8, 32'h000004F1);
    rd(8'h03, r32, r8); chk("t5u_hi32", r32, 32'h00000004); chk("t5u_hi8", r8, 32'h0);

    // Test 6: asynchronous reset between edges during EXEC
    wr(8'h05, 32'h1);
    repeat (5) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_irq", {31'b0, irq32}, 32'h0);
    rd(8'h07, r32, r8); chk("t6_status", r32, 32'h0);
    rd(8'h00, r32, r8); chk("t6_opa", r32, 32'h0);
    rd(8'h04, r32, r8); chk("t6_inten", r32, 32'h0);
    rd(8'h03, r32, r8); chk("t6_hi", r32, 32'h0);
    chk("t6_dout_idle", dout32, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
